// File: rtl/ctech_lib_sync_event_arbiter.sv
// ctech_lib_sync_event_arbiter
// Concentrates N_SRC asynchronous level-toggle event sources into one
// valid/ready channel in the clk domain.
//
// Each source goes through a set-style 3-flop synchronizer, modelled after
// the ctech_lib_triplesync_set cell. Reset loads the synchronizer with 1, so
// an input that is held high through reset never produces an event.
//
// A rising edge on a source increments that source's pending counter. A
// one-entry output slot presents one event at a time. The slot picks the
// next source round-robin from rr_ptr.
//
// Optional feature macro: CTECH_SYNC_EVT_DROP_CNT_EN
//   When defined, the block adds output drop_cnt[7:0]. This is a saturating
//   total of all evt_drop bits.
//
// Slot FSM
//   state   | meaning
//   S_EMPTY | no event presented (evt_vld=0)
//   S_FULL  | evt_id presented, held until evt_rdy

module ctech_lib_sync_event_arbiter #(
   parameter  int N_SRC = 4,
   parameter  int CNT_W = 2,
   localparam int ID_W  = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [N_SRC-1:0] async_in,
   output logic             evt_vld,
   output logic [ID_W-1:0]  evt_id,
   input  logic             evt_rdy,
   output logic [N_SRC-1:0] evt_drop,
`ifdef CTECH_SYNC_EVT_DROP_CNT_EN
   output logic [7:0]       drop_cnt,
`endif
   output logic             busy
);

   typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ID_W:0]    N_SRC_EXT = (ID_W+1)'(N_SRC);
   localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_SRC - 1);

   logic [N_SRC-1:0] sync_1, sync_2, sync_3, sync_q;
   logic [N_SRC-1:0] edge_det;
   logic [N_SRC-1:0] load;
   logic [N_SRC-1:0] drop_nxt;
   logic [N_SRC-1:0] cnt_nz;
   logic [CNT_W-1:0] cnt [N_SRC];

   slot_state_t      slot_state;
   logic [ID_W-1:0]  rr_ptr;
   logic             slot_free;
   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic [ID_W-1:0]  win_next;

   // Set-style triple synchronizer plus one delay stage for edge detection.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         sync_1 <= '1;
         sync_2 <= '1;
         sync_3 <= '1;
         sync_q <= '1;
      end else begin
         sync_1 <= async_in;
         sync_2 <= sync_1;
         sync_3 <= sync_2;
         sync_q <= sync_3;
      end
   end

   assign edge_det = sync_3 & ~sync_q;

   // Round-robin scan: walk from rr_ptr downward in priority so the lowest offset wins.
   always_comb begin
      logic [ID_W:0] sum;
      win_found = 1'b0;
      win_id    = '0;
      sum       = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (sum >= N_SRC_EXT) sum = sum - N_SRC_EXT;
         if (cnt[sum[ID_W-1:0]] != '0) begin
            win_found = 1'b1;
            win_id    = sum[ID_W-1:0];
         end
      end
   end

   assign slot_free = (slot_state == S_EMPTY) || evt_rdy;
   assign win_next  = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

   // One-hot pull from the winning counter whenever the slot reloads.
   always_comb begin
      load = '0;
      if (slot_free && win_found) load[win_id] = 1'b1;
   end

   // Drop happens only when a new edge meets a full counter that is not draining this cycle.
   always_comb begin
      drop_nxt = '0;
      cnt_nz   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         drop_nxt[i] = edge_det[i] && !load[i] && (cnt[i] == CNT_MAX);
         cnt_nz[i]   = (cnt[i] != '0);
      end
   end

   // Pending counters: +edge, -load, saturate at max.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
         evt_drop <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (edge_det[i] && !load[i] && (cnt[i] != CNT_MAX))
               cnt[i] <= cnt[i] + 1'b1;
            else if (!edge_det[i] && load[i])
               cnt[i] <= cnt[i] - 1'b1;
         end
         evt_drop <= drop_nxt;
      end
   end

   // Output slot FSM; evt_id and rr_ptr only move on a load.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         slot_state <= S_EMPTY;
         evt_id     <= '0;
         rr_ptr     <= '0;
      end else begin
         case (slot_state)
            S_EMPTY: begin
               if (win_found) begin
                  slot_state <= S_FULL;
                  evt_id     <= win_id;
                  rr_ptr     <= win_next;
               end
            end
            S_FULL: begin
               if (evt_rdy) begin
                  if (win_found) begin
                     evt_id <= win_id;
                     rr_ptr <= win_next;
                  end else begin
                     slot_state <= S_EMPTY;
                  end
               end
            end
            default: slot_state <= S_EMPTY;
         endcase
      end
   end

   assign evt_vld = (slot_state == S_FULL);
   assign busy    = evt_vld || (|cnt_nz);

`ifdef CTECH_SYNC_EVT_DROP_CNT_EN
   logic [8:0] drop_sum;

   // Add this cycle's drop pulses to the running total, clamped at 255.
   always_comb begin
      drop_sum = {1'b0, drop_cnt};
      for (int i = 0; i < N_SRC; i++) drop_sum = drop_sum + 9'(evt_drop[i]);
   end

   // Saturating loss counter.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)              drop_cnt <= '0;
      else if (drop_sum > 9'd255) drop_cnt <= 8'd255;
      else                     drop_cnt <= drop_sum[7:0];
   end
`endif

endmodule
